sub1024_result_collector: RTL
=============================

Name: sub1024_result_collector

Overview:
- Downstream stage of the 1024-bit word-serial subtractor.
- Captures the 32-bit difference words, least significant word first, one per cycle, into a 1024-bit result buffer, and latches the final borrow.
- Signals completion to the controlling FSM.
- Exposes the stored result through a word-addressed read port for the HPS/Avalon read-back path.

Parameters:
- W, 32, width of one difference word.
- NUM_WORDS, 32, words per operand (1024/W).
- AW, 5, read/word-index address width; must satisfy 2**AW >= NUM_WORDS.

Ports:
- iClk  input  1  system clock, all logic on rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iStart  input  1  single-cycle pulse: arm collector for a new 1024-bit result.
- iValid  input  1  iZ carries a valid difference word this cycle.
- iZ  input  W  difference word from subtractor.
- iBorrow  input  1  subtractor borrow-out (bit W of difference) for the word on iZ.
- iRdAddr  input  AW  word index for read-back.
- oRdData  output  W  stored word at iRdAddr, one-cycle latency.
- oBusy  output  1  high while collecting.
- oDone  output  1  high from completion until next iStart.
- oBorrow  output  1  borrow of most significant word; 1 means X < Y.
- oOverrun  output  1  sticky: valid word arrived while not collecting.
- oWordCnt  output  AW+1  words captured so far.

Behaviour:
- Reset, asynchronous on iRst_n low:
  - State=IDLE.
  - oBusy, oDone, oBorrow, oOverrun = 0.
  - oWordCnt = 0.
  - oRdData = 0.
  - Buffer contents are not reset; readers must gate on oDone.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - iStart → COLLECT next cycle.
  - On that edge: cnt ← 0, oBorrow ← 0, oOverrun ← 0, oDone ← 0, oBusy ← 1.
- COLLECT:
  - Each cycle with iValid=1: buf[cnt] ← iZ, cnt ← cnt+1.
  - iValid=0 inserts a bubble: no write, no count change, no timeout.
  - When iValid=1 and cnt==NUM_WORDS-1: write the word, oBorrow ← iBorrow, cnt ← NUM_WORDS, → DONE, oBusy ← 0, oDone ← 1.
  - Intermediate iBorrow values are ignored; the subtractor chains them internally.
- DONE:
  - Holds the result; oDone stays 1.
  - iStart → COLLECT with the same clears as from IDLE. oDone drops on the same edge.
- iStart while in COLLECT: abort the current result and restart at cnt=0.
  - If iValid=1 in the same cycle, that word is discarded (start wins).
- iValid=1 in IDLE or DONE: word not stored, oOverrun ← 1 (sticky until iStart).
- iStart and iValid in the same cycle in IDLE/DONE: start wins, no overrun.
- Latency:
  - Last valid word at edge N → oDone=1 and oBorrow valid after edge N.
  - Full result = NUM_WORDS valid cycles after start, minimum NUM_WORDS+1 cycles from the iStart edge.
- Read port:
  - oRdData ← buf[iRdAddr] registered, one-cycle latency, in any state.
  - iRdAddr >= NUM_WORDS returns 0.
  - Reading the index being written in the same cycle returns the old value (read-before-write).
- Counter: AW+1 bits, saturates at NUM_WORDS; never wraps.

Optional Feature:
- Macro: SUB_RESULT_ZERO_FLAG_EN.
- When defined:
  - Adds output oZero (1 bit), reset 0.
  - An internal accumulator is set to 1 on start and ANDed with (iZ==0) for every stored word.
  - oZero = accumulator AND oDone, i.e. X==Y, valid in the same cycle as oDone.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sub1024_pkg holds:
  - W, NUM_WORDS, AW constants.
  - State encoding constants for IDLE/COLLECT/DONE (2 bits).
  - Read-out address mask.
- One natural sub-module: sub1024_word_ram.
  - NUM_WORDS×W, one write port, one registered read port, read-before-write.
  - Mappable to M10K.
- FSM, counter and flags stay in the top.

Test Plan:
- Basic capture:
  - Stimulus: reset, iStart, then 32 back-to-back iValid words iZ=k (k=0..31), borrow 0 on last word.
  - Response: oDone=1 after the 32nd edge; oWordCnt=32; oBorrow=0; iRdAddr=k reads k one cycle later.
- Borrow and bubbles:
  - Stimulus: iStart, 32 words 0xFFFFFFFF with iValid=0 bubbles inserted at words 5 and 20; iBorrow=1 only on the final word.
  - Response: oDone only after 32 valid words (34 cycles); oBorrow=1.
- Abort:
  - Stimulus: iStart, 10 words, iStart again with iValid=1, then 32 words of 0xA5A5A5A5.
  - Response: all 32 stored words read 0xA5A5A5A5; oWordCnt=32.
- Overrun:
  - Stimulus: after DONE, pulse iValid with iZ=0x12345678.
  - Response: oOverrun=1, buf unchanged; next iStart clears oOverrun.
- Async reset:
  - Stimulus: assert iRst_n=0 mid-COLLECT (word 17), asynchronously between edges.
  - Response: oBusy, oDone, oWordCnt clear immediately without a clock edge; after release, a full collection succeeds.
- Zero flag (SUB_RESULT_ZERO_FLAG_EN):
  - Stimulus: all 32 words 0, then a repeat run with word 31 = 1.
  - Response: oZero=1 with oDone on the first run, 0 on the second.

Source files
------------

// File: rtl/sub1024_pkg.sv
// Shared constants and types for the 1024-bit word-serial subtractor result path.
//   W            : width of one difference word
//   NUM_WORDS    : words per 1024-bit operand
//   AW           : word-index / read address width (2**AW >= NUM_WORDS)
//   state_e      : collector FSM encoding (2 bits)
//   RD_ADDR_MASK : mask applied to in-range read addresses
package sub1024_pkg;

  localparam int unsigned W         = 32;
  localparam int unsigned NUM_WORDS = 32;
  localparam int unsigned AW        = 5;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_COLLECT = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StCollect = ST_COLLECT,
    StDone    = ST_DONE
  } state_e;

  // NUM_WORDS is a power of two here, so the mask maps any in-range index onto itself.
  localparam logic [AW-1:0] RD_ADDR_MASK = AW'(NUM_WORDS - 1);

endpackage

// File: rtl/sub1024_word_ram.sv
// NUM_WORDS x W result buffer: one write port, one registered read port.
// Ports:
//   iClk     : clock
//   iRst_n   : async active-low reset (clears only the read data register)
//   iWe      : write enable
//   iWrAddr  : write word index
//   iWrData  : write data
//   iRdAddr  : read word index; out-of-range indices read as zero
//   oRdData  : registered read data, one-cycle latency, read-before-write
module sub1024_word_ram
  import sub1024_pkg::*;
#(
  parameter int unsigned W         = sub1024_pkg::W,
  parameter int unsigned NUM_WORDS = sub1024_pkg::NUM_WORDS,
  parameter int unsigned AW        = sub1024_pkg::AW
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iWe,
  input  logic [AW-1:0] iWrAddr,
  input  logic [W-1:0]  iWrData,
  input  logic [AW-1:0] iRdAddr,
  output logic [W-1:0]  oRdData
);

  logic [W-1:0] mem [NUM_WORDS];
  logic [W-1:0] rdDataQ;
  logic         rdInRange;

  assign rdInRange = ({1'b0, iRdAddr} < (AW + 1)'(NUM_WORDS));

  // Storage has no reset so the array can map onto block RAM.
  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem[iWrAddr] <= iWrData;
    end
  end

  // Non-blocking read of mem yields the pre-write contents on a same-cycle collision.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rdDataQ <= '0;
    end else if (rdInRange) begin
      rdDataQ <= mem[iRdAddr & RD_ADDR_MASK];
    end else begin
      rdDataQ <= '0;
    end
  end

  assign oRdData = rdDataQ;

endmodule

// File: rtl/sub1024_result_collector.sv
// Collects the difference words of a 1024-bit word-serial subtraction (LSW first),
// latches the final borrow, flags completion and offers word-addressed read-back.
// Optional feature: define SUB_RESULT_ZERO_FLAG_EN to add oZero (result == 0, i.e. X == Y).
// Ports:
//   iClk, iRst_n : clock, async active-low reset
//   iStart       : pulse, arm (or re-arm/abort) a collection
//   iValid, iZ   : difference word strobe and data
//   iBorrow      : borrow-out for the word on iZ; only the last word's value is kept
//   iRdAddr      : read-back word index
//   oRdData      : stored word at iRdAddr, one-cycle latency
//   oBusy/oDone  : collecting / result complete
//   oBorrow      : final borrow (1 means X < Y)
//   oOverrun     : sticky, a word arrived while not collecting
//   oWordCnt     : words captured so far (saturates at NUM_WORDS)
//   oZero        : (optional) result is all zeros, valid with oDone
module sub1024_result_collector
  import sub1024_pkg::*;
#(
  parameter int unsigned W         = sub1024_pkg::W,
  parameter int unsigned NUM_WORDS = sub1024_pkg::NUM_WORDS,
  parameter int unsigned AW        = sub1024_pkg::AW
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iStart,
  input  logic          iValid,
  input  logic [W-1:0]  iZ,
  input  logic          iBorrow,
  input  logic [AW-1:0] iRdAddr,
  output logic [W-1:0]  oRdData,
  output logic          oBusy,
  output logic          oDone,
  output logic          oBorrow,
  output logic          oOverrun,
`ifdef SUB_RESULT_ZERO_FLAG_EN
  output logic          oZero,
`endif
  output logic [AW:0]   oWordCnt
);

  localparam logic [AW:0] LastCnt = (AW + 1)'(NUM_WORDS - 1);
  localparam logic [AW:0] FullCnt = (AW + 1)'(NUM_WORDS);

  state_e      stateQ, stateD;
  logic [AW:0] cntQ, cntD;
  logic        borrowQ, borrowD;
  logic        overrunQ, overrunD;
  logic        zeroAccQ, zeroAccD;
  logic        wordWe;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ   <= StIdle;
      cntQ     <= '0;
      borrowQ  <= 1'b0;
      overrunQ <= 1'b0;
      zeroAccQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      borrowQ  <= borrowD;
      overrunQ <= overrunD;
      zeroAccQ <= zeroAccD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    borrowD  = borrowQ;
    overrunD = overrunQ;
    zeroAccD = zeroAccQ;
    wordWe   = 1'b0;

    // Start takes priority in every state and discards any coincident word.
    if (iStart) begin
      stateD   = StCollect;
      cntD     = '0;
      borrowD  = 1'b0;
      overrunD = 1'b0;
      zeroAccD = 1'b1;
    end else begin
      unique case (stateQ)
        StCollect: begin
          if (iValid) begin
            wordWe   = 1'b1;
            zeroAccD = zeroAccQ & (iZ == '0);
            if (cntQ < FullCnt) begin
              cntD = cntQ + 1'b1;
            end
            if (cntQ == LastCnt) begin
              borrowD = iBorrow;
              stateD  = StDone;
            end
          end
        end
        StIdle, StDone: begin
          if (iValid) begin
            overrunD = 1'b1;
          end
        end
        default: begin
          stateD = StIdle;
        end
      endcase
    end
  end

  sub1024_word_ram #(
    .W        (W),
    .NUM_WORDS(NUM_WORDS),
    .AW       (AW)
  ) uWordRam (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iWe    (wordWe),
    .iWrAddr(cntQ[AW-1:0]),
    .iWrData(iZ),
    .iRdAddr(iRdAddr),
    .oRdData(oRdData)
  );

  assign oBusy    = (stateQ == StCollect);
  assign oDone    = (stateQ == StDone);
  assign oBorrow  = borrowQ;
  assign oOverrun = overrunQ;
  assign oWordCnt = cntQ;

`ifdef SUB_RESULT_ZERO_FLAG_EN
  assign oZero = zeroAccQ & oDone;
`else
  // Accumulator is unused without the zero flag and is optimised away.
  logic unusedZeroAcc;
  assign unusedZeroAcc = zeroAccQ;
`endif

endmodule
